// File: rtl/user_packetizer.sv
// Buffers HLS output words and stamps them into 49-bit BFT packets (valid, leaf, port, seq, payload),
// releasing one packet per cycle while credits remain.
module user_packetizer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 4,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int FIFO_DEPTH    = 8,
    parameter int CREDIT_INIT   = 64,
    parameter int CREDIT_BITS   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PAYLOAD_BITS-1:0]         din,
    input  logic                            din_ap_vld,
    output logic                            din_ap_ack,
    input  logic                            cfg_en,
    input  logic [NUM_LEAF_BITS-1:0]        cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]        cfg_dest_port,
    input  logic                            credit_ret,
    input  logic [CREDIT_BITS-1:0]          credit_ret_cnt,
    output logic [PACKET_BITS-1:0]          dout_packet,
    output logic [CREDIT_BITS-1:0]          credit_cnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int PAD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - NUM_ADDR_BITS - PAYLOAD_BITS;
    localparam int SEQ_LSB  = PAYLOAD_BITS + PAD_BITS;
    localparam int PORT_LSB = SEQ_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

    localparam logic [PTR_BITS:0]    FIFO_FULL_CNT = (PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [CREDIT_BITS:0] CREDIT_SAT    = (CREDIT_BITS + 1)'(CREDIT_INIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PAYLOAD_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]        count_q, count_d;
    logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
    logic [CREDIT_BITS-1:0]   credit_q, credit_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     wr_en;
    logic                     emit;
    logic [CREDIT_BITS:0]     credit_sum;

    always_comb begin
        fifo_full  = (count_q == FIFO_FULL_CNT);
        fifo_empty = (count_q == '0);
        din_ap_ack = din_ap_vld & (state_q == S_RUN) & ~fifo_full;
        wr_en      = din_ap_vld & din_ap_ack;
        emit       = ~fifo_empty & (credit_q != '0) & (state_q != S_IDLE);

        wr_ptr_d = wr_ptr_q + {{(PTR_BITS-1){1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{(PTR_BITS-1){1'b0}}, emit};
        count_d  = count_q + {{PTR_BITS{1'b0}}, wr_en} - {{PTR_BITS{1'b0}}, emit};
        seq_d    = seq_q + {{(NUM_ADDR_BITS-1){1'b0}}, emit};

        dout_d = '0;
        if (emit) begin
            dout_d[PACKET_BITS-1]                      = 1'b1;
            dout_d[LEAF_LSB +: NUM_LEAF_BITS]          = cfg_dest_leaf;
            dout_d[PORT_LSB +: NUM_PORT_BITS]          = cfg_dest_port;
            dout_d[SEQ_LSB +: NUM_ADDR_BITS]           = seq_q;
            dout_d[PAYLOAD_BITS-1:0]                   = mem_q[rd_ptr_q];
        end

        // emit implies credit_q != 0, so the subtraction never wraps; one extra bit absorbs the return
        credit_sum = {1'b0, credit_q} - {{CREDIT_BITS{1'b0}}, emit};
        if (credit_ret) begin
            credit_sum = credit_sum + {1'b0, credit_ret_cnt};
        end
        credit_d = (credit_sum > CREDIT_SAT) ? CREDIT_SAT[CREDIT_BITS-1:0] : credit_sum[CREDIT_BITS-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_en) state_d = S_RUN;
            end
            S_RUN: begin
                if (!cfg_en) state_d = (!fifo_empty || wr_en) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (cfg_en)              state_d = S_RUN;
                else if (count_d == '0)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            credit_q <= CREDIT_SAT[CREDIT_BITS-1:0];
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            credit_q <= credit_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout_packet = dout_q;
    assign credit_cnt  = credit_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_user_packetizer.sv
// Randomized bench for user_packetizer, checked every cycle against a queue-based packet/credit model.
module tb_user_packetizer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_ap_vld;
    logic        din_ap_ack;
    logic        cfg_en;
    logic [3:0]  cfg_dest_leaf;
    logic [3:0]  cfg_dest_port;
    logic        credit_ret;
    logic [7:0]  credit_ret_cnt;
    logic [48:0] dout_packet;
    logic [7:0]  credit_cnt;
    logic [3:0]  fifo_count;

    user_packetizer dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .din_ap_vld     (din_ap_vld),
        .din_ap_ack     (din_ap_ack),
        .cfg_en         (cfg_en),
        .cfg_dest_leaf  (cfg_dest_leaf),
        .cfg_dest_port  (cfg_dest_port),
        .credit_ret     (credit_ret),
        .credit_ret_cnt (credit_ret_cnt),
        .dout_packet    (dout_packet),
        .credit_cnt     (credit_cnt),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: payload queue, credit pool, sequence number, enable mode
    bit [31:0]   mq[$];
    int          m_credit;
    int          m_seq;
    int          m_mode;
    logic [48:0] m_dout;
    int          n_emitted;
    int          max_cnt;

    bit          last_vld;
    bit          last_ack;
    bit [31:0]   last_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_credit = 64;
        m_seq    = 0;
        m_mode   = M_IDLE;
        m_dout   = '0;
        last_vld = 1'b0;
        last_ack = 1'b0;
    endtask

    task automatic check_regs();
        chk("dout_packet", dout_packet, m_dout);
        chk("credit_cnt", credit_cnt, m_credit);
        chk("fifo_count", fifo_count, mq.size());
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    endtask

    task automatic cycle(input bit en, input bit vld, input bit [31:0] d, input bit ret,
                         input bit [7:0] rc, input bit [3:0] leaf, input bit [3:0] port);
        bit exp_ack;
        bit emit;
        int sz_w;
        @(negedge clk);
        check_regs();
        cfg_en         = en;
        din_ap_vld     = vld;
        din            = d;
        credit_ret     = ret;
        credit_ret_cnt = rc;
        cfg_dest_leaf  = leaf;
        cfg_dest_port  = port;
        #1;
        exp_ack = vld && (m_mode == M_RUN) && (mq.size() < 8);
        chk("din_ap_ack", din_ap_ack, exp_ack);

        emit = (mq.size() > 0) && (m_credit > 0) && (m_mode != M_IDLE);
        sz_w = mq.size() + int'(exp_ack);
        if (emit) begin
            m_dout = (49'(1) << 48) | (49'(leaf) << 44) | (49'(port) << 40)
                   | (49'(m_seq) << 33) | 49'(mq[0]);
            void'(mq.pop_front());
            m_seq = (m_seq + 1) % 128;
            n_emitted++;
        end else begin
            m_dout = '0;
        end
        if (exp_ack) mq.push_back(d);
        m_credit = m_credit - int'(emit) + (ret ? int'(rc) : 0);
        if (m_credit > 64) m_credit = 64;
        case (m_mode)
            M_IDLE:  if (en) m_mode = M_RUN;
            M_RUN:   if (!en) m_mode = (sz_w > 0) ? M_DRAIN : M_IDLE;
            default: begin
                if (en) m_mode = M_RUN;
                else if (mq.size() == 0) m_mode = M_IDLE;
            end
        endcase
        last_vld = vld;
        last_ack = exp_ack;
        last_d   = d;
        @(posedge clk);
    endtask

    // Random traffic; a refused word is held unchanged until it is taken
    task automatic run(input int n, input bit en, input int vld_pct, input int ret_pct, input int rc_max);
        bit        vld;
        bit [31:0] d;
        bit        ret;
        for (int i = 0; i < n; i++) begin
            if (last_vld && !last_ack) begin
                vld = 1'b1;
                d   = last_d;
            end else begin
                vld = ($urandom_range(99) < vld_pct);
                d   = $urandom;
            end
            ret = ($urandom_range(99) < ret_pct);
            cycle(en, vld, d, ret, 8'($urandom_range(rc_max)),
                  4'($urandom_range(15)), 4'($urandom_range(15)));
        end
    endtask

    initial begin
        n_emitted      = 0;
        max_cnt        = 0;
        reset          = 1'b0;
        cfg_en         = 1'b1;
        din_ap_vld     = 1'b1;
        din            = 32'h1234_5678;
        credit_ret     = 1'b0;
        credit_ret_cnt = '0;
        cfg_dest_leaf  = '0;
        cfg_dest_port  = '0;
        model_reset();
        #12;
        chk("rst_dout", dout_packet, 49'h0);
        chk("rst_credit", credit_cnt, 8'd64);
        chk("rst_fifo", fifo_count, 4'd0);
        chk("rst_ack", din_ap_ack, 1'b0);
        @(negedge clk);
        reset      = 1'b1;
        cfg_en     = 1'b0;
        din_ap_vld = 1'b0;

        // Single word: accepted in the same cycle, packet on the following edge
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 8'd0, 4'h3, 4'h2);
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'd0, 4'h3, 4'h2);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 8'd0, 4'h3, 4'h2);
        #1;
        chk("first_packet", dout_packet, 49'h1_3200_DEAD_BEEF);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 8'd0, 4'h3, 4'h2);

        // Ten back-to-back words with credits available
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 8'd0, 4'h5, 4'h9);
        end
        run(3, 1'b1, 0, 0, 0);
        chk("b2b_max_fifo", max_cnt, 1);
        chk("b2b_credit", credit_cnt, 8'd53);

        // Exhaust credits, FIFO fills and ack drops while the offered word is held
        run(80, 1'b1, 100, 0, 0);
        #1;
        chk("stall_credit", credit_cnt, 8'd0);
        chk("stall_fifo_full", fifo_count, 4'd8);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 8'd2, 4'h1, 4'h1);
        run(5, 1'b1, 0, 0, 0);
        chk("two_credit_fifo", fifo_count, 4'd6);

        // Mixed traffic with returns; includes large returns that hit the ceiling
        run(200, 1'b1, 70, 40, 4);
        run(6, 1'b1, 0, 100, 200);
        #1;
        chk("saturated", credit_cnt, 8'd64);
        run(300, 1'b1, 80, 30, 3);
        chk("seq_wrapped", (n_emitted > 130), 1'b1);

        // Fill with no credits, disable, then drain with a credit return
        run(90, 1'b1, 100, 0, 0);
        run(3, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 8'd12, 4'h7, 4'h4);
        run(12, 1'b0, 0, 0, 0);
        #1;
        chk("drained_fifo", fifo_count, 4'd0);
        chk("drain_idle", (m_mode == M_IDLE), 1'b1);

        // Repeat, but reset in the middle of draining
        run(4, 1'b1, 0, 0, 0);
        run(80, 1'b1, 100, 0, 0);
        run(2, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 8'd3, 4'hE, 4'hD);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 4'hE, 4'hD);
        #2;
        cfg_en     = 1'b0;
        credit_ret = 1'b0;
        reset      = 1'b0;
        #1;
        chk("midrst_dout", dout_packet, 49'h0);
        chk("midrst_fifo", fifo_count, 4'd0);
        chk("midrst_credit", credit_cnt, 8'd64);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        run(60, 1'b1, 60, 20, 3);
        run(10, 1'b0, 0, 50, 3);
        @(negedge clk);
        check_regs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/user_packetizer.md
Name: user_packetizer

Overview:
- Sits between an HLS operator's Output_k_V_V stream (ap_vld/ap_ack) and one input slot of leaf_interface, on the user-to-BFT side.
- Buffers 32-bit payload words in a small FIFO and stamps each with destination leaf, destination port and a wrapping sequence address.
- Emits one 49-bit BFT packet per cycle, gated by a credit counter that mirrors receiver free space.

Parameters:
- PACKET_BITS, 49, total packet width.
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 4, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, sequence address field width.
- FIFO_DEPTH, 8, payload FIFO entries; must be a power of 2 and at least 2.
- CREDIT_INIT, 64, credits after reset; also the saturation ceiling.
- CREDIT_BITS, 8, credit counter width; must hold CREDIT_INIT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- din  in  PAYLOAD_BITS  payload from HLS Output_k_V_V.
- din_ap_vld  in  1  payload valid.
- din_ap_ack  out  1  payload accepted this cycle.
- cfg_en  in  1  1 = accept new words.
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf, sampled per packet at emission.
- cfg_dest_port  in  NUM_PORT_BITS  destination port, sampled per packet at emission.
- credit_ret  in  1  credit-return strobe.
- credit_ret_cnt  in  CREDIT_BITS  credits returned with the strobe.
- dout_packet  out  PACKET_BITS  packet to leaf_interface.
- credit_cnt  out  CREDIT_BITS  current credits.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Packet format, MSB to LSB:
  - bit PACKET_BITS-1 = valid.
  - dest leaf (NUM_LEAF_BITS).
  - dest port (NUM_PORT_BITS).
  - seq addr (NUM_ADDR_BITS).
  - zero padding (PACKET_BITS-1-NUM_LEAF_BITS-NUM_PORT_BITS-NUM_ADDR_BITS-PAYLOAD_BITS bits; 1 bit at defaults; must be >= 0).
  - payload.
- Reset values, asynchronous on reset=0:
  - dout_packet = 0, din_ap_ack = 0, credit_cnt = CREDIT_INIT, fifo_count = 0, seq addr = 0, state = IDLE.
  - FIFO contents are discarded.
- Reset asserted mid-operation: a packet in flight is dropped and dout_packet goes to 0 without waiting for a clock edge.
- Accept handshake:
  - din_ap_ack = din_ap_vld & accept_ok & !fifo_full. This is combinational; no wait states when space exists.
  - accept_ok = (state == RUN).
  - A word is written on a rising edge where din_ap_vld & din_ap_ack = 1.
  - din must be held while din_ap_vld=1 and din_ap_ack=0.
- Emit condition at each edge: fifo nonempty AND credit_cnt != 0 AND state != IDLE.
  - When true: dout_packet is registered with valid=1, the current cfg_dest_leaf/cfg_dest_port, seq addr, and the FIFO head. The FIFO pops and seq addr increments.
  - When false: dout_packet is registered to all zeros.
  - valid is therefore high exactly one cycle per packet. Throughput is 1 packet/cycle.
- Latency: with the FIFO empty and credits > 0, a word accepted at edge k appears on dout_packet after edge k+1.
- seq addr wraps 2^NUM_ADDR_BITS-1 -> 0.
- Credits, next value each edge = credit_cnt - emit + (credit_ret ? credit_ret_cnt : 0).
  - Simultaneous emit and return are netted in the same edge.
  - Result saturates at CREDIT_INIT and never underflows.
- FIFO:
  - Simultaneous write and pop on the same edge is legal; fifo_count stays unchanged.
  - A write while full is impossible because ack is gated by full.
  - Pop from empty never occurs.
- FSM:
  - IDLE -> RUN when cfg_en=1.
  - RUN -> DRAIN when cfg_en=0 and FIFO nonempty (counting a same-edge write).
  - RUN -> IDLE when cfg_en=0 and FIFO empty.
  - DRAIN -> IDLE when FIFO becomes empty.
  - DRAIN -> RUN when cfg_en=1.
  - In DRAIN: ack=0, emission continues. In IDLE: no ack, no emission.

Test Plan:
- Reset, cfg_en=1, cfg_dest_leaf=3, cfg_dest_port=2, din=0xDEADBEEF with vld for one cycle -> ack the same cycle; one cycle later dout_packet = {1,4'h3,4'h2,7'd0,1'b0,32'hDEADBEEF}; then dout_packet = 0.
- Continuous vld for 10 words with CREDIT_INIT=64 -> 10 back-to-back packets, seq 0..9; credit_cnt=54; fifo_count never exceeds 1.
- CREDIT_INIT=4, 8 words pushed, no returns -> 4 packets emitted, fifo_count=4, then stall. credit_ret=1 with cnt=2 -> exactly 2 more packets.
- Credits exhausted and 12 words offered with FIFO_DEPTH=8 -> ack high for 8 words then low; fifo_count=8; din held stable and not lost.
- 130 packets emitted -> seq addr 127 followed by 0. credit_ret cnt=10 on the same edge as an emit with credit_cnt=60 -> credit_cnt=64, saturated.
- 5 words queued, cfg_en=0, credits>0 -> ack=0, all 5 packets drain, FSM reaches IDLE. Apply reset=0 mid-drain on a repeat run -> dout_packet=0 immediately, fifo_count=0, credit_cnt=CREDIT_INIT.
